// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider: one quotient bit per clock, start/busy/done handshake.
// Optional reconstruction self-check is enabled by defining DIV_SELFCHECK_EN.
module seq_restoring_divider #(
    parameter int DIVIDEND_W = 8,
    parameter int DIVISOR_W  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  busy,
    output logic                  done,
    output logic [DIVIDEND_W-1:0] quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero,
    output logic                  check_err
);

    localparam int CNT_W  = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
    localparam int PR_W   = DIVISOR_W + 1;
    localparam int PROD_W = DIVIDEND_W + DIVISOR_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [PR_W-1:0]       pr_q, pr_d;
    logic [DIVIDEND_W-1:0] acc_q, acc_d;
    logic [DIVIDEND_W-1:0] dvd_q, dvd_d;
    logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
    logic [DIVIDEND_W-1:0] quo_q, quo_d;
    logic [DIVISOR_W-1:0]  rem_q, rem_d;
    logic                  dbz_q, dbz_d;

    logic                  accept;
    logic [PR_W-1:0]       pr_shift;
    logic [PR_W-1:0]       pr_step;
    logic                  fits;
    logic [DIVIDEND_W-1:0] acc_step;
    logic                  recon_bad;

    assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        pr_shift = {pr_q[DIVISOR_W-1:0], dvd_q[cnt_q]};
        fits     = (pr_shift >= {1'b0, dvs_q});
        pr_step  = fits ? (pr_shift - {1'b0, dvs_q}) : pr_shift;
        acc_step = acc_q;
        acc_step[cnt_q] = fits;
    end

`ifdef DIV_SELFCHECK_EN
    logic [PROD_W-1:0] recon;
    logic              chk_q, chk_d;

    // Rebuild the dividend from the final quotient/remainder about to be loaded.
    always_comb begin
        recon     = PROD_W'(acc_step) * PROD_W'(dvs_q) + PROD_W'(pr_step[DIVISOR_W-1:0]);
        recon_bad = (recon != PROD_W'(dvd_q));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chk_q <= 1'b0;
        end else begin
            chk_q <= chk_d;
        end
    end

    always_comb begin
        chk_d = 1'b0;
        if ((state_q == S_CALC) && (cnt_q == '0)) begin
            chk_d = recon_bad;
        end
    end

    assign check_err = chk_q;
`else
    assign recon_bad = 1'b0;
    assign check_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            pr_q    <= '0;
            acc_q   <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pr_q    <= pr_d;
            acc_q   <= acc_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pr_d    = pr_q;
        acc_d   = acc_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept) begin
                    dvd_d = dividend;
                    dvs_d = divisor;
                    if (divisor != '0) begin
                        pr_d    = '0;
                        acc_d   = '0;
                        cnt_d   = CNT_W'(DIVIDEND_W - 1);
                        state_d = S_CALC;
                    end else begin
                        // Divide by zero short-circuits straight to a result.
                        quo_d   = '1;
                        rem_d   = '0;
                        dbz_d   = 1'b1;
                        state_d = S_DONE;
                    end
                end
            end
            S_CALC: begin
                pr_d  = pr_step;
                acc_d = acc_step;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    cnt_d   = '0;
                    quo_d   = acc_step;
                    rem_d   = pr_step[DIVISOR_W-1:0];
                    dbz_d   = 1'b0;
                    state_d = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy        = (state_q == S_CALC);
    assign done        = (state_q == S_DONE);
    assign quotient    = quo_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Directed bench for seq_restoring_divider: hand-computed vectors plus a full operand sweep
// checked against integer division.
module tb_seq_restoring_divider;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] dividend = '0;
    logic [3:0] divisor = '0;
    logic       busy;
    logic       done;
    logic [7:0] quotient;
    logic [3:0] remainder;
    logic       div_by_zero;
    logic       check_err;

    int total = 0;
    int bad = 0;

    seq_restoring_divider #(.DIVIDEND_W(8), .DIVISOR_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dividend   (dividend),
        .divisor    (divisor),
        .busy       (busy),
        .done       (done),
        .quotient   (quotient),
        .remainder  (remainder),
        .div_by_zero(div_by_zero),
        .check_err  (check_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Present operands with start for one edge; returns just after the accept edge.
    task automatic issue(input logic [7:0] a, input logic [3:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts cycles from the accept edge (first cycle after it is 1) until done.
    task automatic wait_done(output int lat);
        lat = 1;
        while (!done && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("done_seen", done, 1);
    endtask

    task automatic run_div(input string tag, input logic [7:0] a, input logic [3:0] b,
                           input logic [7:0] eq, input logic [3:0] er, input logic edbz,
                           input int elat);
        int lat;
        issue(a, b);
        wait_done(lat);
        chk({tag, "_lat"}, lat, elat);
        chk({tag, "_q"}, quotient, eq);
        chk({tag, "_r"}, remainder, er);
        chk({tag, "_dbz"}, div_by_zero, edbz);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_cerr"}, check_err, 0);
    endtask

    initial begin
        int lat;
        int done_cnt;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_q", quotient, 0);
        chk("rst_r", remainder, 0);
        chk("rst_dbz", div_by_zero, 0);
        chk("rst_cerr", check_err, 0);
        @(negedge clk);
        rst = 1'b0;

        run_div("d143_11", 8'd143, 4'd11, 8'd13, 4'd0, 1'b0, 9);
        @(posedge clk);
        #1;
        chk("pulse_len", done, 0);
        chk("idle_hold_q", quotient, 13);

        issue(8'd200, 4'd7);
        chk("busy_calc", busy, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("calc_hold_q", quotient, 13);
        wait_done(lat);
        chk("d200_7_q", quotient, 28);
        chk("d200_7_r", remainder, 4);

        run_div("d225_15", 8'd225, 4'd15, 8'd15, 4'd0, 1'b0, 9);
        run_div("d5_9", 8'd5, 4'd9, 8'd0, 4'd5, 1'b0, 9);
        run_div("d37_0", 8'd37, 4'd0, 8'd255, 4'd0, 1'b1, 1);
        run_div("after_dbz", 8'd100, 4'd10, 8'd10, 4'd0, 1'b0, 9);

        // Start during CALC is ignored and operand changes do not disturb the run.
        issue(8'd200, 4'd7);
        repeat (2) @(posedge clk);
        @(negedge clk);
        dividend = 8'd99;
        divisor  = 4'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat);
        chk("ign_lat", lat, 6);
        chk("ign_q", quotient, 28);
        chk("ign_r", remainder, 4);

        // Back-to-back: start on the done cycle.
        dividend = 8'd99;
        divisor  = 4'd3;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b_busy", busy, 1);
        chk("b2b_hold_q", quotient, 28);
        wait_done(lat);
        chk("b2b_lat", lat, 9);
        chk("b2b_q", quotient, 33);
        chk("b2b_r", remainder, 0);

        // Reset mid-computation aborts with no done.
        issue(8'd200, 4'd7);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_q", quotient, 0);
        chk("mid_rst_r", remainder, 0);
        chk("mid_rst_dbz", div_by_zero, 0);
        done_cnt = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) done_cnt++;
        end
        chk("mid_rst_no_done", done_cnt, 0);
        run_div("d255_15", 8'd255, 4'd15, 8'd17, 4'd0, 1'b0, 9);

        // Full operand sweep against integer division.
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 16; b++) begin
                issue(8'(a), 4'(b));
                wait_done(lat);
                if (b == 0) begin
                    chk("sw_lat", lat, 1);
                    chk("sw_q", quotient, 255);
                    chk("sw_r", remainder, 0);
                    chk("sw_dbz", div_by_zero, 1);
                end else begin
                    chk("sw_lat", lat, 9);
                    chk("sw_q", quotient, 32'(a / b));
                    chk("sw_r", remainder, 32'(a % b));
                    chk("sw_dbz", div_by_zero, 0);
                end
                chk("sw_cerr", check_err, 0);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
